composite_video_gen: RTL

Parametrised composite-video (NTSC/PAL-style) signal generator driving a small resistor-ladder DAC. Timing and clock division are set by parameters. Pixels are fetched from an external framebuffer through a request/latency interface rather than generated internally. The colour burst comes from a numerically controlled phase accumulator. Output levels are prioritised and clamped. The block sits between the video framebuffer/arbiter and the board-level DAC pins.

---
 rtl/composite_video_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/composite_video_gen.sv
// Composite-video generator: slot timing, pixel fetch requests, burst from an
// NCO phase accumulator, and prioritised, clamped DAC level output.
// Pipeline: tick at (x,y) -> stage 1 registers request and region ->
// stage 2 samples pix_data and registers the DAC code.
module composite_video_gen #(
    parameter int unsigned DATA_BITS   = 4,
    parameter int unsigned PIX_BITS    = 4,
    parameter int unsigned CLK_DIV     = 5,
    parameter int unsigned H_TOTAL     = 636,
    parameter int unsigned H_ACTIVE    = 526,
    parameter int unsigned HSYNC_START = 541,
    parameter int unsigned HSYNC_END   = 588,
    parameter int unsigned BURST_START = 600,
    parameter int unsigned BURST_END   = 620,
    parameter int unsigned V_TOTAL     = 313,
    parameter int unsigned V_ACTIVE    = 268,
    parameter int unsigned VSYNC_START = 276,
    parameter int unsigned VSYNC_END   = 280,
    parameter int unsigned BLANK_LVL   = 2,
    parameter int unsigned BURST_AMP   = 1,
    parameter int unsigned PHASE_BITS  = 16,
    parameter int unsigned PHASE_INC   = 4692
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 pix_req,
    output logic [9:0]           pix_x,
    output logic [8:0]           pix_y,
    input  logic [PIX_BITS-1:0]  pix_data,
    output logic [DATA_BITS-1:0] v_data,
    output logic                 v_sync,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SUM_W    = DATA_BITS + 1;
    localparam int unsigned CODE_MAX = (2 ** DATA_BITS) - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       X_HS0    = 10'(HSYNC_START);
    localparam logic [9:0]       X_HS1    = 10'(HSYNC_END);
    localparam logic [9:0]       X_BS0    = 10'(BURST_START);
    localparam logic [9:0]       X_BS1    = 10'(BURST_END);
    localparam logic [8:0]       Y_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0]       Y_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0]       Y_VS0    = 9'(VSYNC_START);
    localparam logic [8:0]       Y_VS1    = 9'(VSYNC_END);

    localparam logic [DATA_BITS-1:0] BLANK_CODE = DATA_BITS'(BLANK_LVL);
    localparam logic [DATA_BITS-1:0] BURST_HI   = DATA_BITS'(BLANK_LVL + BURST_AMP);
    localparam logic [DATA_BITS-1:0] BURST_LO   = DATA_BITS'(BLANK_LVL - BURST_AMP);
    localparam logic [DATA_BITS-1:0] CLAMP_CODE = DATA_BITS'(CODE_MAX);

    typedef enum logic [1:0] {RgnBlank, RgnActive, RgnBurst, RgnSync} region_e;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [9:0]            x_q, x_d;
    logic [8:0]            y_q, y_d;
    logic [PHASE_BITS-1:0] phase_q;
    logic                  tick;

    region_e               region_d, region_q;
    logic                  s1_valid_q;

    logic [SUM_W-1:0]      act_sum;
    logic [DATA_BITS-1:0]  code_d;

    assign tick = enable && (div_q == '0);

    // Next-state for the clock divider and slot position; all held at 0 while disabled.
    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        if (!enable) begin
            div_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (tick) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end
    end

    // Divider and slot position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    // Subcarrier NCO runs regardless of enable so burst phase never jumps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + PHASE_BITS'(PHASE_INC);
        end
    end

    // Region decode of the current slot, first match wins.
    always_comb begin
        region_d = RgnBlank;
        if (y_q >= Y_VS0 && y_q < Y_VS1) begin
            region_d = RgnSync;
        end else if (x_q >= X_HS0 && x_q < X_HS1 && y_q < Y_ACT) begin
            region_d = RgnSync;
        end else if (x_q >= X_BS0 && x_q < X_BS1 && y_q < Y_ACT) begin
            region_d = RgnBurst;
        end else if (x_q < X_ACT && y_q < Y_ACT) begin
            region_d = RgnActive;
        end
    end

    // Stage 1: fetch request, slot coordinates, line/frame markers and region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            region_q    <= RgnBlank;
            s1_valid_q  <= 1'b0;
        end else if (!enable) begin
            pix_req     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            region_q    <= RgnBlank;
            s1_valid_q  <= 1'b0;
        end else begin
            pix_req     <= tick && (region_d == RgnActive);
            line_start  <= tick && (x_q == '0);
            frame_start <= tick && (x_q == '0) && (y_q == '0);
            s1_valid_q  <= tick;
            if (tick) begin
                pix_x    <= x_q;
                pix_y    <= y_q;
                region_q <= region_d;
            end
        end
    end

    // DAC code for the stage-1 region; luma sum is one bit wider so it can clamp.
    always_comb begin
        act_sum = SUM_W'(BLANK_LVL + 1) + SUM_W'(pix_data);
        code_d  = BLANK_CODE;
        case (region_q)
            RgnSync:   code_d = '0;
            RgnBurst:  code_d = phase_q[PHASE_BITS-1] ? BURST_HI : BURST_LO;
            RgnActive: code_d = (act_sum > SUM_W'(CODE_MAX)) ? CLAMP_CODE
                                                              : act_sum[DATA_BITS-1:0];
            default:   code_d = BLANK_CODE;
        endcase
    end

    // Stage 2: register the level once per slot and hold it until the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_data <= BLANK_CODE;
            v_sync <= 1'b1;
        end else if (!enable) begin
            v_data <= BLANK_CODE;
            v_sync <= 1'b1;
        end else if (s1_valid_q) begin
            v_data <= code_d;
            v_sync <= (region_q != RgnSync);
        end
    end

endmodule
